// File: rtl/stage3_execute.sv
// Execute stage: registers the decoded bundle and produces the ALU result,
// the branch decision and the branch target. MUL/DIVU/REMU use a shared
// 32-step iterative unit and hold the front of the pipe while it runs.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | single-cycle op in flight, or a multicycle op waiting to start
// BUSY  | iterating: shift-add (MUL) or restoring shift-subtract (DIVU/REMU)
// DONE  | iterative result valid on alu_o; waits for stage4 to accept it
module stage3_execute (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] off_i,
   input  logic [3:0]  alu_op_i,
   input  logic        branch_i,
   input  logic [2:0]  cond_i,
   input  logic        control_load_i,
   input  logic        control_store_i,
   input  logic        do_wb_i,
   input  logic [4:0]  wb_reg_i,
   input  logic        stall_i,
   output logic        stall_o,
   output logic [31:0] alu_o,
   output logic        control_load_o,
   output logic        control_store_o,
   output logic        control_take_branch_o,
   output logic [31:0] branch_target_o,
   output logic        do_wb_o,
   output logic [4:0]  wb_reg_o
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_DIVU = 4'd11;
   localparam logic [3:0] OP_REMU = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // input bundle register
   logic [31:0] a_q, pc_q, off_q, b_q;
   logic [3:0]  op_q;
   logic        branch_q, load_q, store_q, do_wb_q;
   logic [2:0]  cond_q;
   logic [4:0]  wb_reg_q;

   // iterative unit
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;   // MUL accumulator / divide remainder
   logic [31:0] opa_q, opa_d;   // MUL multiplicand / divide quotient
   logic [31:0] opb_q, opb_d;   // MUL multiplier / divisor

   logic        is_mc;
   logic        load_en;
   logic [32:0] rem_sh;
   logic [32:0] rem_diff;
   logic [31:0] mc_res;
   logic [31:0] alu_res;
   logic        cond_met;

   assign is_mc   = (op_q == OP_MUL) || (op_q == OP_DIVU) || (op_q == OP_REMU);
   assign stall_o = ((state_q == S_IDLE) && is_mc) || (state_q == S_BUSY);
   assign load_en = !stall_o && !stall_i;

   // bundle register: loads only when neither this stage nor stage4 stalls
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q      <= '0;
         b_q      <= '0;
         pc_q     <= '0;
         off_q    <= '0;
         op_q     <= OP_ADD;
         branch_q <= 1'b0;
         cond_q   <= '0;
         load_q   <= 1'b0;
         store_q  <= 1'b0;
         do_wb_q  <= 1'b0;
         wb_reg_q <= '0;
      end else if (load_en) begin
         a_q      <= a_i;
         b_q      <= b_i;
         pc_q     <= pc_i;
         off_q    <= off_i;
         op_q     <= alu_op_i;
         branch_q <= branch_i;
         cond_q   <= cond_i;
         load_q   <= control_load_i;
         store_q  <= control_store_i;
         do_wb_q  <= do_wb_i;
         wb_reg_q <= wb_reg_i;
      end
   end

   // iterative unit state and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
      end
   end

   // shift-and-trial-subtract step; a zero divisor always "fits", which
   // yields an all-ones quotient and leaves the dividend as remainder
   assign rem_sh   = {acc_q, opa_q[31]};
   assign rem_diff = rem_sh - {1'b0, opb_q};

   // next-state and iteration step
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      case (state_q)
         S_IDLE: begin
            if (is_mc) begin
               state_d = S_BUSY;
               cnt_d   = 6'd32;
               acc_d   = '0;
               opa_d   = a_q;
               opb_d   = b_q;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = S_DONE;
            end
            if (op_q == OP_MUL) begin
               if (opb_q[0]) begin
                  acc_d = acc_q + opa_q;
               end
               opa_d = {opa_q[30:0], 1'b0};
               opb_d = {1'b0, opb_q[31:1]};
            end else if (rem_sh >= {1'b0, opb_q}) begin
               acc_d = rem_diff[31:0];
               opa_d = {opa_q[30:0], 1'b1};
            end else begin
               acc_d = rem_sh[31:0];
               opa_d = {opa_q[30:0], 1'b0};
            end
         end
         S_DONE: begin
            if (!stall_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mc_res = (op_q == OP_DIVU) ? opa_q : acc_q;

   // single-cycle ALU
   always_comb begin
      alu_res = b_q;
      case (op_q)
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SLL:  alu_res = a_q << b_q[4:0];
         OP_SRL:  alu_res = a_q >> b_q[4:0];
         OP_SRA:  alu_res = $unsigned($signed(a_q) >>> b_q[4:0]);
         OP_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
         OP_SLTU: alu_res = {31'd0, a_q < b_q};
         OP_MUL, OP_DIVU, OP_REMU: alu_res = mc_res;
         default: alu_res = b_q;
      endcase
   end

   // branch condition, A against B
   always_comb begin
      cond_met = 1'b0;
      case (cond_q)
         3'd0: cond_met = 1'b1;
         3'd1: cond_met = (a_q == b_q);
         3'd2: cond_met = (a_q != b_q);
         3'd3: cond_met = $signed(a_q) < $signed(b_q);
         3'd4: cond_met = $signed(a_q) >= $signed(b_q);
         3'd5: cond_met = a_q < b_q;
         3'd6: cond_met = a_q >= b_q;
         default: cond_met = 1'b0;
      endcase
   end

   assign alu_o                 = (state_q == S_DONE) ? mc_res : alu_res;
   assign branch_target_o       = pc_q + off_q;
   assign wb_reg_o              = wb_reg_q;
   assign control_load_o        = load_q && !stall_o;
   assign control_store_o       = store_q && !stall_o;
   assign control_take_branch_o = branch_q && cond_met && !stall_o;
   assign do_wb_o               = do_wb_q && (wb_reg_q != 5'd0) && !stall_o;

endmodule

// File: tb/tb_stage3_execute.sv
// Directed bench for stage3_execute: reset, ALU sweep, branches, iterative
// MUL/DIVU/REMU timing, downstream stall, reset mid-op and r0 writeback.
module tb_stage3_execute;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] a_i, b_i, pc_i, off_i;
   logic [3:0]  alu_op_i;
   logic        branch_i;
   logic [2:0]  cond_i;
   logic        control_load_i, control_store_i, do_wb_i;
   logic [4:0]  wb_reg_i;
   logic        stall_i;
   logic        stall_o;
   logic [31:0] alu_o;
   logic        control_load_o, control_store_o, control_take_branch_o;
   logic [31:0] branch_target_o;
   logic        do_wb_o;
   logic [4:0]  wb_reg_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_sweep [10] = '{32'h80000005, 32'h7FFFFFFD, 32'h00000000,
                                   32'h80000005, 32'h80000005, 32'h00000010,
                                   32'h08000000, 32'hF8000000, 32'h00000001,
                                   32'h00000000};

   stage3_execute dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .a_i                   (a_i),
      .b_i                   (b_i),
      .pc_i                  (pc_i),
      .off_i                 (off_i),
      .alu_op_i              (alu_op_i),
      .branch_i              (branch_i),
      .cond_i                (cond_i),
      .control_load_i        (control_load_i),
      .control_store_i       (control_store_i),
      .do_wb_i               (do_wb_i),
      .wb_reg_i              (wb_reg_i),
      .stall_i               (stall_i),
      .stall_o               (stall_o),
      .alu_o                 (alu_o),
      .control_load_o        (control_load_o),
      .control_store_o       (control_store_o),
      .control_take_branch_o (control_take_branch_o),
      .branch_target_o       (branch_target_o),
      .do_wb_o               (do_wb_o),
      .wb_reg_o              (wb_reg_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after the issuing edge; counts stall cycles, ends in DONE.
   task automatic run_mc(input string tag, input logic [31:0] exp_res);
      int cnt;
      cnt = 0;
      while (stall_o === 1'b1 && cnt < 100) begin
         check({tag, "_bubble_wb"}, {31'd0, do_wb_o}, 32'd0);
         cnt++;
         tick();
      end
      check({tag, "_stall_cycles"}, cnt, 33);
      check({tag, "_result"}, alu_o, exp_res);
      check({tag, "_do_wb"}, {31'd0, do_wb_o}, 32'd1);
   endtask

   initial begin
      // reset with random inputs
      rst_i = 1'b1;
      a_i = $urandom; b_i = $urandom; pc_i = $urandom; off_i = $urandom;
      alu_op_i = 4'($urandom_range(0, 15)); branch_i = 1'b1; cond_i = 3'd0;
      control_load_i = 1'b1; control_store_i = 1'b1; do_wb_i = 1'b1;
      wb_reg_i = 5'd7; stall_i = 1'b0;
      tick();
      tick();
      check("rst_alu", alu_o, 32'd0);
      check("rst_target", branch_target_o, 32'd0);
      check("rst_ctrl", {28'd0, control_load_o, control_store_o, control_take_branch_o, do_wb_o}, 32'd0);
      check("rst_wbreg", {27'd0, wb_reg_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);

      // ALU sweep
      rst_i = 1'b0;
      branch_i = 1'b0; control_load_i = 1'b0; control_store_i = 1'b0;
      do_wb_i = 1'b1; wb_reg_i = 5'd3; pc_i = 32'd0; off_i = 32'd0;
      a_i = 32'h80000001; b_i = 32'h00000004;
      for (int i = 0; i < 10; i++) begin
         alu_op_i = 4'(i);
         tick();
         check($sformatf("alu_op%0d", i), alu_o, exp_sweep[i]);
      end
      check("sweep_do_wb", {31'd0, do_wb_o}, 32'd1);
      check("sweep_wbreg", {27'd0, wb_reg_o}, 32'd3);

      // branches
      alu_op_i = 4'd0; branch_i = 1'b1; cond_i = 3'd3;
      a_i = 32'hFFFFFFFF; b_i = 32'd1; pc_i = 32'h100; off_i = 32'hFFFFFFF0;
      tick();
      check("br_lt_take", {31'd0, control_take_branch_o}, 32'd1);
      check("br_target", branch_target_o, 32'h000000F0);
      cond_i = 3'd5;
      tick();
      check("br_ltu_take", {31'd0, control_take_branch_o}, 32'd0);
      branch_i = 1'b0;

      // downstream stall with single-cycle op: bundle held
      alu_op_i = 4'd0; a_i = 32'd10; b_i = 32'd20; control_load_i = 1'b1;
      tick();
      check("sc_add", alu_o, 32'd30);
      check("sc_load", {31'd0, control_load_o}, 32'd1);
      stall_i = 1'b1; a_i = 32'd99; control_load_i = 1'b0;
      tick();
      tick();
      check("sc_stall_hold", alu_o, 32'd30);
      check("sc_stall_load", {31'd0, control_load_o}, 32'd1);
      stall_i = 1'b0;

      // MUL then back-to-back DIVU and REMU
      do_wb_i = 1'b1; wb_reg_i = 5'd4;
      alu_op_i = 4'd10; a_i = 32'h00010000; b_i = 32'h00010001;
      tick();
      alu_op_i = 4'd11; a_i = 32'd100; b_i = 32'd7;
      run_mc("mul", 32'h00010000);
      tick();
      alu_op_i = 4'd12;
      run_mc("divu", 32'd14);
      tick();
      alu_op_i = 4'd11; a_i = 32'd5; b_i = 32'd0;
      run_mc("remu", 32'd2);

      // divide by zero, then downstream stall while in DONE
      tick();
      alu_op_i = 4'd0; a_i = 32'd1; b_i = 32'd2;
      run_mc("div0", 32'hFFFFFFFF);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("div0_hold%0d", i), alu_o, 32'hFFFFFFFF);
         check($sformatf("div0_nostall%0d", i), {31'd0, stall_o}, 32'd0);
      end
      stall_i = 1'b0;
      tick();
      check("after_hold_add", alu_o, 32'd3);

      // reset on BUSY cycle 10
      alu_op_i = 4'd11; a_i = 32'd1000; b_i = 32'd3;
      tick();
      tick();
      for (int i = 0; i < 9; i++) tick();
      check("busy_before_rst", {31'd0, stall_o}, 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
      check("rst_mid_alu", alu_o, 32'd0);

      // writeback to r0 suppressed
      alu_op_i = 4'd0; a_i = 32'd6; b_i = 32'd7; do_wb_i = 1'b1; wb_reg_i = 5'd0;
      tick();
      check("r0_alu", alu_o, 32'd13);
      check("r0_do_wb", {31'd0, do_wb_o}, 32'd0);
      wb_reg_i = 5'd9;
      tick();
      check("r9_do_wb", {31'd0, do_wb_o}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
